// File: rtl/ula_pkg.sv
// Shared types for the multi-cycle ALU: opcode map, FSM states and flag bit positions.
package ula_pkg;

  typedef enum logic [2:0] {
    OP_NOT = 3'd0,
    OP_AND = 3'd1,
    OP_OR  = 3'd2,
    OP_XOR = 3'd3,
    OP_ADD = 3'd4,
    OP_SUB = 3'd5,
    OP_SLL = 3'd6,
    OP_SRL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic is_shift(input op_e op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/ula_core.sv
// Combinational single-cycle ALU datapath with {Z,N,C,V} flag generation.
// With ULA_MULTICICLO_BARREL_EN the shifts are done here in one cycle; otherwise only the rb boundary cases.
module ula_core
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           c;
  logic           v;

  assign sum  = {1'b0, a} + {1'b0, b};
  // diff[WIDTH] is the borrow, i.e. a < b unsigned
  assign diff = {1'b0, a} - {1'b0, b};

`ifdef ULA_MULTICICLO_BARREL_EN
  localparam logic [WIDTH-1:0] W_VAL = WIDTH[WIDTH-1:0];
  logic [WIDTH:0] sll_ext;
  logic [WIDTH:0] srl_ext;

  // One guard bit on the outgoing side captures the last bit shifted out
  assign sll_ext = {1'b0, a} << b;
  assign srl_ext = {a, 1'b0} >> b;
`endif

  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    unique case (op)
      OP_NOT: result = ~a;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        c      = diff[WIDTH];
        v      = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
`ifdef ULA_MULTICICLO_BARREL_EN
      OP_SLL: begin
        if (b < W_VAL) begin
          result = sll_ext[WIDTH-1:0];
          c      = sll_ext[WIDTH];
        end
      end
      OP_SRL: begin
        if (b < W_VAL) begin
          result = srl_ext[WIDTH:1];
          c      = srl_ext[0];
        end
      end
`else
      // Only rb==0 and rb>=WIDTH reach here; in-range shifts run in the FSM
      OP_SLL, OP_SRL: begin
        if (b == '0) result = a;
      end
`endif
      default: result = '0;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
  end

endmodule

// File: rtl/ula_multiciclo.sv
// Registered multi-cycle ALU with start/busy/done handshake; shifts iterate one bit per cycle.
// ULA_MULTICICLO_BARREL_EN routes shifts through EXEC using a single-cycle barrel shifter.
//   state    | meaning
//   ST_IDLE  | waiting for start; latches operands
//   ST_EXEC  | registers the combinational result, pulses done
//   ST_SHIFT | shifts acc one bit per cycle until cnt reaches 0
module ula_multiciclo
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] rb,
  input  logic [2:0]       opcode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  state_e           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  op_e              op_q;
  logic [WIDTH-1:0] core_result;
  logic [3:0]       core_flags;

`ifndef ULA_MULTICICLO_BARREL_EN
  localparam logic [WIDTH-1:0] W_VAL = WIDTH[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] cnt;
  logic             shift_c;
  logic             go_shift;

  assign go_shift = is_shift(op_e'(opcode)) && (rb != '0) && (rb < W_VAL);
`endif

  ula_core #(.WIDTH(WIDTH)) u_core (
    .a      (op_a),
    .b      (op_b),
    .op     (op_q),
    .result (core_result),
    .flags  (core_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      op_a    <= '0;
      op_b    <= '0;
      op_q    <= OP_NOT;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      flags   <= '0;
`ifndef ULA_MULTICICLO_BARREL_EN
      acc     <= '0;
      cnt     <= '0;
      shift_c <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            op_a <= ra;
            op_b <= rb;
            op_q <= op_e'(opcode);
            busy <= 1'b1;
`ifndef ULA_MULTICICLO_BARREL_EN
            if (go_shift) begin
              acc     <= ra;
              cnt     <= rb;
              shift_c <= 1'b0;
              state   <= ST_SHIFT;
            end else begin
              state <= ST_EXEC;
            end
`else
            state <= ST_EXEC;
`endif
          end
        end
        ST_EXEC: begin
          result <= core_result;
          flags  <= core_flags;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
`ifndef ULA_MULTICICLO_BARREL_EN
        ST_SHIFT: begin
          if (cnt != '0) begin
            if (op_q == OP_SLL) begin
              shift_c <= acc[WIDTH-1];
              acc     <= {acc[WIDTH-2:0], 1'b0};
            end else begin
              shift_c <= acc[0];
              acc     <= {1'b0, acc[WIDTH-1:1]};
            end
            cnt <= cnt - ONE;
          end else begin
            result        <= acc;
            flags[FLAG_Z] <= (acc == '0);
            flags[FLAG_N] <= acc[WIDTH-1];
            flags[FLAG_C] <= shift_c;
            flags[FLAG_V] <= 1'b0;
            done          <= 1'b1;
            busy          <= 1'b0;
            state         <= ST_IDLE;
          end
        end
`endif
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Self-checking bench for ula_multiciclo (WIDTH=8): vector table, corner sequences, random ops vs. model.
module tb_ula_multiciclo;

  localparam int W = 8;
`ifdef ULA_MULTICICLO_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] ra = '0;
  logic [W-1:0] rb = '0;
  logic [2:0]   opcode = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [3:0]   flags;

  int checks = 0;
  int errors = 0;

  ula_multiciclo #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .ra     (ra),
    .rb     (rb),
    .opcode (opcode),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flags  (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int op;
    int res;
    int fl;
    int lat_iter;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model from the arithmetic definition of each operation
  task automatic model(input int a, input int b, input int op,
                       output int res, output int fl, output int lat);
    int s, sa, sb, c, v;
    c = 0;
    v = 0;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (op)
      0: res = 255 - a;
      1: res = a & b;
      2: res = a | b;
      3: res = a ^ b;
      4: begin
        s = a + b; res = s % 256; c = (s > 255) ? 1 : 0;
        v = ((sa + sb) > 127 || (sa + sb) < -128) ? 1 : 0;
      end
      5: begin
        s = a - b; res = (s + 256) % 256; c = (a < b) ? 1 : 0;
        v = ((sa - sb) > 127 || (sa - sb) < -128) ? 1 : 0;
      end
      6: begin
        if (b >= W) res = 0;
        else if (b == 0) res = a;
        else begin res = (a * (1 << b)) % 256; c = (a >> (W - b)) & 1; end
      end
      default: begin
        if (b >= W) res = 0;
        else if (b == 0) res = a;
        else begin res = a >> b; c = (a >> (b - 1)) & 1; end
      end
    endcase
    fl = ((res == 0) ? 8 : 0) + ((res >= 128) ? 4 : 0) + c * 2 + v;
    lat = (op >= 6 && b > 0 && b < W && !BARREL) ? b + 1 : 1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      if (busy && done) begin
        errors++;
        $display("FAIL busy_done_overlap: busy=%0b done=%0b", busy, done);
      end
      if (done) break;
      if (n >= 40) begin
        errors++;
        $display("FAIL done_timeout: no done after %0d cycles", n);
        n = -1;
        break;
      end
    end
  endtask

  task automatic issue(input int a, input int b, input int op);
    @(negedge clk);
    ra = a[W-1:0]; rb = b[W-1:0]; opcode = op[2:0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_latch", {31'd0, busy}, 32'd1);
  endtask

  task automatic run_check(input string name, input int a, input int b, input int op,
                           input int exp_res, input int exp_fl, input int exp_lat);
    int n;
    issue(a, b, op);
    wait_done(n);
    chk({name, "_latency"}, n, exp_lat);
    chk({name, "_result"}, {24'd0, result}, exp_res);
    chk({name, "_flags"}, {28'd0, flags}, exp_fl);
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, {30'd0, busy, done}, 32'd0);
  endtask

  vec_t vecs[15];

  initial begin
    int n, total, er, ef, el, a, b, op;

    vecs[0]  = '{200, 100, 4, 44,   4'b0010, 1};
    vecs[1]  = '{100, 100, 4, 200,  4'b0101, 1};
    vecs[2]  = '{5,   7,   5, 'hFE, 4'b0110, 1};
    vecs[3]  = '{7,   7,   5, 0,    4'b1000, 1};
    vecs[4]  = '{'h81, 3,  6, 'h08, 4'b0000, 4};
    vecs[5]  = '{'h81, 1,  7, 'h40, 4'b0010, 2};
    vecs[6]  = '{'hFF, 9,  7, 0,    4'b1000, 1};
    vecs[7]  = '{'h5A, 0,  6, 'h5A, 4'b0000, 1};
    vecs[8]  = '{'h0F, 0,  0, 'hF0, 4'b0100, 1};
    vecs[9]  = '{'hF0, 'h3C, 1, 'h30, 4'b0000, 1};
    vecs[10] = '{0,    0,  2, 0,    4'b1000, 1};
    vecs[11] = '{'hAA, 'h55, 3, 'hFF, 4'b0100, 1};
    vecs[12] = '{'h80, 7,  7, 'h01, 4'b0000, 8};
    vecs[13] = '{'h80, 8,  6, 0,    4'b1000, 1};
    vecs[14] = '{'h03, 7,  6, 'h80, 4'b0110, 8};

    #1;
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_result", {24'd0, result}, 0);
    chk("reset_flags", {28'd0, flags}, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
                vecs[i].res, vecs[i].fl, BARREL ? 1 : vecs[i].lat_iter);

    // start while busy must not re-latch operands
    issue('h81, 3, 6);
    @(negedge clk);
    ra = 8'hFF; rb = 8'd1; opcode = 3'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (done) total = 1;
    else begin
      wait_done(n);
      total = (n < 0) ? -1 : n + 1;
    end
    chk("ignore_latency", total, BARREL ? 1 : 4);
    chk("ignore_result", {24'd0, result}, 'h08);
    chk("ignore_flags", {28'd0, flags}, 0);
    @(posedge clk); #1;
    chk("ignore_no_second_op", {30'd0, busy, done}, 0);

    // start held high: next op is accepted on the done cycle
    @(negedge clk);
    ra = 8'd200; rb = 8'd100; opcode = 3'd4; start = 1'b1;
    @(posedge clk); #1;
    ra = 8'd1; rb = 8'd2;
    wait_done(n);
    chk("b2b_first_latency", n, 1);
    chk("b2b_first_result", {24'd0, result}, 44);
    @(posedge clk); #1;
    chk("b2b_accepted", {30'd0, busy, done}, 32'd2);
    start = 1'b0;
    wait_done(n);
    chk("b2b_second_latency", n, 1);
    chk("b2b_second_result", {24'd0, result}, 3);

    // reset in the middle of a shift
    issue('h81, 3, 6);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_done", {31'd0, done}, 0);
    chk("midrst_result", {24'd0, result}, 0);
    chk("midrst_flags", {28'd0, flags}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_check("post_reset", 200, 100, 4, 44, 4'b0010, 1);

    for (int k = 0; k < 80; k++) begin
      a  = int'($urandom_range(0, 255));
      b  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 255));
      op = int'($urandom_range(0, 7));
      model(a, b, op, er, ef, el);
      run_check($sformatf("rand%0d_op%0d_a%0d_b%0d", k, op, a, b), a, b, op, er, ef, el);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/ula_multiciclo.md
Name: ula_multiciclo

Overview:
- Parametrised, registered, multi-cycle successor of the 8-bit combinational ULA.
- Same 3-bit opcode map: NOT, AND, OR, XOR, ADD, SUB, SLL, SRL. Width is a parameter.
- Start/busy/done handshake. Status flags. Shifts run iteratively, one bit per cycle, so no barrel shifter is needed.
- Sits between the register file and the writeback stage of the Redux-V datapath; the control unit stalls on busy.

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- ra  in  WIDTH  operand A.
- rb  in  WIDTH  operand B; the shift amount for SLL/SRL.
- opcode  in  3  0 NOT, 1 AND, 2 OR, 3 XOR, 4 ADD, 5 SUB, 6 SLL, 7 SRL.
- busy  out  1  operation in progress.
- done  out  1  single-cycle pulse when result/flags update.
- result  out  WIDTH  registered result; holds until the next completion.
- flags  out  4  {Z, N, C, V}; registered together with result.

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset (async assert, sync release): state IDLE, result 0, flags 0, busy 0, done 0. Reset mid-operation aborts it; no done is produced.
- States: IDLE, EXEC, SHIFT.
- IDLE, start=1 at edge k:
  - Latch ra, rb, opcode; busy<=1.
  - Shift op with 0 < rb < WIDTH: go to SHIFT with acc=ra and cnt=rb.
  - Every other case: go to EXEC.
- EXEC: at edge k+1, result/flags computed from the latched operands are registered; done<=1, busy<=0, go to IDLE. Latency 1.
- SHIFT:
  - Each edge with cnt>0: acc shifts by 1 (SLL in 0 at LSB, SRL in 0 at MSB); cnt-1; the bit shifted out is kept.
  - Edge with cnt==0: result<=acc, done<=1, busy<=0, go to IDLE. Latency rb+1.
- Shift-amount boundaries:
  - rb==0: result=ra, C=0, latency 1.
  - rb>=WIDTH (full-width unsigned compare): result=0, C=0, latency 1.
- done is high for exactly one cycle. busy and done are never both high.
- start while busy is ignored; operands are not re-latched.
- start in the same cycle as done high (FSM already in IDLE) is accepted, giving back-to-back issue.
- Arithmetic is modulo 2^WIDTH.
- Flags:
  - Z = (result==0). N = result[WIDTH-1].
  - C: carry-out for ADD; borrow (ra<rb unsigned) for SUB; last bit shifted out for SLL/SRL; 0 for logic ops.
  - V: signed overflow for ADD/SUB; 0 otherwise.

Optional Feature:
- Macro ULA_MULTICICLO_BARREL_EN.
- Defined: SLL/SRL go through EXEC with a single-cycle barrel shift. Latency is 1 for every op; the SHIFT state is unused/removed. C = last bit shifted out, with the same rb boundary rules.
- Undefined: iterative SHIFT behaviour as above.

Decomposition:
- Package ula_pkg: opcode enum (OP_NOT..OP_SRL), FSM state enum, flag bit indices (FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0).
- Sub-module ula_core: purely combinational single-cycle ops plus ADD/SUB carry and overflow, parametrised by WIDTH.
- The top level holds the FSM, operand registers, shift accumulator/counter, and the output registers.

Test Plan (WIDTH=8):
- ADD ra=200 rb=100, start at edge 0 -> done at edge 1; result=44, flags Z0 N0 C1 V0.
- ADD ra=100 rb=100 -> result=200, N1 V1 C0. SUB ra=5 rb=7 -> result=0xFE, N1 C1 V0. SUB ra=7 rb=7 -> result=0, Z1.
- SLL ra=0x81 rb=3 -> busy for 3 cycles after the latch edge, done at edge 4; result=0x08, C0. SRL ra=0x81 rb=1 -> done at edge 2; result=0x40, C1.
- SRL ra=0xFF rb=9 -> done at edge 1; result=0, Z1 C0. SLL rb=0, ra=0x5A -> result=0x5A, latency 1.
- start pulsed during a busy SLL with different operands -> ignored, original result delivered. start held high -> a new op is accepted on the done cycle.
- rst_n low mid-SHIFT -> busy, done, result and flags go to 0 immediately. After release, the next op completes normally.
- With ULA_MULTICICLO_BARREL_EN: SLL ra=0x81 rb=3 -> done at edge 1, result=0x08.
